// File: rtl/vga_timing_gen.sv
// Raster timing generator for 1024x768 video.
// Counters plus sync/blank/frame flags, all registered.
package vga_pkg;
  localparam int HOR_TOTAL_TIME  = 1344;
  localparam int HOR_SYNC_START  = 1048;
  localparam int HOR_SYNC_END    = 1184;
  localparam int HOR_BLANK_START = 1024;
  localparam int HOR_BLANK_END   = 1344;
  localparam int VER_TOTAL_TIME  = 806;
  localparam int VER_SYNC_START  = 771;
  localparam int VER_SYNC_END    = 777;
  localparam int VER_BLANK_START = 768;
  localparam int VER_BLANK_END   = 806;
endpackage

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_TOTAL       = HOR_TOTAL_TIME,
  parameter int H_SYNC_START  = HOR_SYNC_START,
  parameter int H_SYNC_END    = HOR_SYNC_END,
  parameter int H_BLANK_START = HOR_BLANK_START,
  parameter int H_BLANK_END   = HOR_BLANK_END,
  parameter int V_TOTAL       = VER_TOTAL_TIME,
  parameter int V_SYNC_START  = VER_SYNC_START,
  parameter int V_SYNC_END    = VER_SYNC_END,
  parameter int V_BLANK_START = VER_BLANK_START,
  parameter int V_BLANK_END   = VER_BLANK_END,
  parameter int CNT_W         = 11
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic             hsync,
  output logic             hblnk,
  output logic [CNT_W-1:0] vcount,
  output logic             vsync,
  output logic             vblnk,
  output logic             frame_start
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t HT_M1 = cnt_t'(H_TOTAL - 1);
  localparam cnt_t VT_M1 = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HSS   = cnt_t'(H_SYNC_START);
  localparam cnt_t HSE   = cnt_t'(H_SYNC_END);
  localparam cnt_t HBS   = cnt_t'(H_BLANK_START);
  localparam cnt_t HBE   = cnt_t'(H_BLANK_END);
  localparam cnt_t VSS   = cnt_t'(V_SYNC_START);
  localparam cnt_t VSE   = cnt_t'(V_SYNC_END);
  localparam cnt_t VBS   = cnt_t'(V_BLANK_START);
  localparam cnt_t VBE   = cnt_t'(V_BLANK_END);

  cnt_t h_nxt;
  cnt_t v_nxt;
  logic h_wrap;
  logic v_wrap;

  function automatic logic in_rng(cnt_t x, cnt_t lo, cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

  // Next counter values; flags are derived from these so they align.
  always_comb begin
    h_wrap = (hcount == HT_M1);
    v_wrap = (vcount == VT_M1);
    h_nxt  = h_wrap ? '0 : hcount + 1'b1;
    v_nxt  = vcount;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vcount + 1'b1;
    end
  end

  // Register counters and flags on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= in_rng(h_nxt, HSS, HSE);
      hblnk       <= in_rng(h_nxt, HBS, HBE);
      vsync       <= in_rng(v_nxt, VSS, VSE);
      vblnk       <= in_rng(v_nxt, VBS, VBE);
      frame_start <= h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 1024x768 instance for line
// timing plus a shrunken instance for full-frame behaviour.
module tb_vga_timing_gen;

  localparam int SHT  = 20;
  localparam int SHSS = 12;
  localparam int SHSE = 15;
  localparam int SHBS = 10;
  localparam int SHBE = 20;
  localparam int SVT  = 12;
  localparam int SVSS = 9;
  localparam int SVSE = 10;
  localparam int SVBS = 8;
  localparam int SVBE = 12;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit hb;
    bit vs;
    bit vb;
    bit fs;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [10:0] d_h, d_v;
  logic d_hs, d_hb, d_vs, d_vb, d_fs;
  logic [4:0] s_h, s_v;
  logic s_hs, s_hb, s_vs, s_vb, s_fs;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  smp_t md = '{default: 0};
  smp_t ms = '{default: 0};
  smp_t q_d[$];
  smp_t q_s[$];

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .rst(rst),
    .hcount(d_h), .hsync(d_hs), .hblnk(d_hb),
    .vcount(d_v), .vsync(d_vs), .vblnk(d_vb),
    .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_TOTAL(SHT), .H_SYNC_START(SHSS), .H_SYNC_END(SHSE),
    .H_BLANK_START(SHBS), .H_BLANK_END(SHBE),
    .V_TOTAL(SVT), .V_SYNC_START(SVSS), .V_SYNC_END(SVSE),
    .V_BLANK_START(SVBS), .V_BLANK_END(SVBE),
    .CNT_W(5)
  ) dut_s (
    .clk(clk), .rst(rst),
    .hcount(s_h), .hsync(s_hs), .hblnk(s_hb),
    .vcount(s_v), .vsync(s_vs), .vblnk(s_vb),
    .frame_start(s_fs)
  );

  function automatic smp_t adv(
    smp_t p, bit r,
    int ht, int hss, int hse, int hbs, int hbe,
    int vt, int vss, int vse, int vbs, int vbe
  );
    smp_t n;
    n = '{default: 0};
    if (r) return n;
    n.h = p.h + 1;
    n.v = p.v;
    if (n.h == ht) begin
      n.h = 0;
      n.v = p.v + 1;
      if (n.v == vt) begin
        n.v = 0;
        n.fs = 1;
      end
    end
    n.hs = (n.h >= hss) && (n.h < hse);
    n.hb = (n.h >= hbs) && (n.h < hbe);
    n.vs = (n.v >= vss) && (n.v < vse);
    n.vb = (n.v >= vbs) && (n.v < vbe);
    return n;
  endfunction

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic cmp(string t, smp_t e, int h, int v,
                     bit hs, bit hb, bit vs, bit vb, bit fs);
    check({t, ".hcount"}, h, e.h);
    check({t, ".vcount"}, v, e.v);
    check({t, ".hsync"}, int'(hs), int'(e.hs));
    check({t, ".hblnk"}, int'(hb), int'(e.hb));
    check({t, ".vsync"}, int'(vs), int'(e.vs));
    check({t, ".vblnk"}, int'(vb), int'(e.vb));
    check({t, ".frame_start"}, int'(fs), int'(e.fs));
  endtask

  task automatic tick();
    smp_t e;
    @(posedge clk);
    md = adv(md, rst, 1344, 1048, 1184, 1024, 1344,
             806, 771, 777, 768, 806);
    q_d.push_back(md);
    ms = adv(ms, rst, SHT, SHSS, SHSE, SHBS, SHBE,
             SVT, SVSS, SVSE, SVBS, SVBE);
    q_s.push_back(ms);
    @(negedge clk);
    cyc++;
    e = q_d.pop_front();
    cmp("big", e, int'(d_h), int'(d_v),
        d_hs, d_hb, d_vs, d_vb, d_fs);
    e = q_s.pop_front();
    cmp("small", e, int'(s_h), int'(s_v),
        s_hs, s_hb, s_vs, s_vb, s_fs);
  endtask

  initial begin
    int hs_cnt;
    int hb_cnt;
    int hb_rise;
    int hs_rise;
    bit seen_v1;
    int last_fs;
    int fs_cnt;
    int first_fs;
    bit prev_hb;
    bit prev_hs;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst.hcount", int'(d_h), 0);
    check("rst.flags", int'({d_hs, d_hb, d_vs, d_vb, d_fs}), 0);

    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel.hcount", int'(d_h), 1);
    check("rel.vcount", int'(d_v), 0);
    check("rel.fs", int'(d_fs), 0);

    hs_cnt = 0;
    hb_cnt = 0;
    hb_rise = -1;
    hs_rise = -1;
    seen_v1 = 0;
    last_fs = -1;
    prev_hb = 0;
    prev_hs = 0;
    for (int i = 0; i < 1360; i++) begin
      tick();
      if (d_v == 0 && d_hs) hs_cnt++;
      if (d_v == 0 && d_hb) hb_cnt++;
      if (d_hb && !prev_hb && hb_rise < 0) hb_rise = int'(d_h);
      if (d_hs && !prev_hs && hs_rise < 0) hs_rise = int'(d_h);
      if (d_h == 0 && d_v == 1) seen_v1 = 1;
      prev_hb = d_hb;
      prev_hs = d_hs;
      if (s_fs) begin
        if (last_fs >= 0) check("small.period", cyc - last_fs, SHT * SVT);
        last_fs = cyc;
      end
    end
    check("line.hblnk_rise", hb_rise, 1024);
    check("line.hblnk_len", hb_cnt, 320);
    check("line.hsync_rise", hs_rise, 1048);
    check("line.hsync_len", hs_cnt, 136);
    check("line.vcount_wrap", int'(seen_v1), 1);

    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid.zero_h", int'(s_h) + int'(d_h), 0);
    tick();
    @(negedge clk);
    rst = 1'b0;

    fs_cnt = 0;
    first_fs = -1;
    for (int k = 1; k <= 2 * SHT * SVT; k++) begin
      tick();
      if (k == 1) check("mid.rel_h", int'(s_h), 1);
      if (s_fs) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = k;
      end
    end
    check("mid.first_fs", first_fs, SHT * SVT);
    check("mid.fs_count", fs_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running raster timing generator for the 1024x768 display mode.
- Produces horizontal and vertical pixel counters, sync and blanking flags, and a start-of-frame strobe.
- Sits directly downstream of the shared VGA timing constants package: parameter defaults are taken from it.
- Sits at the head of the video pipeline: its bus feeds the background and rectangle drawing stages.

Parameters:
- H_TOTAL, HOR_TOTAL_TIME (1344): pixels per line, counter modulus.
- H_SYNC_START, HOR_SYNC_START (1048): first hcount with hsync asserted.
- H_SYNC_END, HOR_SYNC_END (1184): first hcount after hsync deasserts.
- H_BLANK_START, HOR_BLANK_START (1024): first hcount with hblnk asserted.
- H_BLANK_END, HOR_BLANK_END (1344): first hcount after hblnk deasserts; equal to H_TOTAL means blank runs to end of line.
- V_TOTAL, VER_TOTAL_TIME (806): lines per frame.
- V_SYNC_START, VER_SYNC_START (771): first vcount with vsync asserted.
- V_SYNC_END, VER_SYNC_END (777): first vcount after vsync deasserts.
- V_BLANK_START, VER_BLANK_START (768): first vcount with vblnk asserted.
- V_BLANK_END, VER_BLANK_END (806): first vcount after vblnk deasserts.
- CNT_W, 11: counter width; must satisfy 2**CNT_W >= max(H_TOTAL, V_TOTAL).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1.
- hsync  out  1  horizontal sync, active-high.
- hblnk  out  1  horizontal blanking, active-high.
- vcount  out  CNT_W  current line, 0..V_TOTAL-1.
- vsync  out  1  vertical sync, active-high.
- vblnk  out  1  vertical blanking, active-high.
- frame_start  out  1  one-cycle strobe coincident with (hcount,vcount) = (0,0) after a frame wrap.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst. All outputs are registered; no combinational path to any output.
- Reset values: hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0, frame_start=0.
- While rst is high: outputs hold reset values on every rising clk edge.
- Horizontal counter:
  - Each cycle with rst low: hcount <= hcount+1.
  - If hcount == H_TOTAL-1: hcount <= 0.
- Vertical counter:
  - vcount increments only on the cycle hcount wraps (hcount == H_TOTAL-1).
  - If it also holds that vcount == V_TOTAL-1: vcount <= 0 (frame wrap).
- Flag alignment:
  - Flags are computed from the next-state counter values and registered in the same edge as the counters.
  - Every output sample is therefore mutually consistent: zero relative latency between counts and flags.
- Flag ranges, start inclusive and end exclusive:
  - hsync = hcount in [H_SYNC_START, H_SYNC_END).
  - hblnk = hcount in [H_BLANK_START, H_BLANK_END).
  - vsync = vcount in [V_SYNC_START, V_SYNC_END).
  - vblnk = vcount in [V_BLANK_START, V_BLANK_END).
- Vertical flags change only at line boundaries, together with vcount.
- frame_start:
  - High for exactly one cycle when the outputs enter (0,0) via a frame wrap.
  - Not asserted during reset.
  - Not asserted on the first cycle after reset release; the counters advance to hcount=1 then.
- First cycle after rst falls: hcount=1, vcount=0, all flags 0.
- Reset mid-frame: the next edge with rst high forces reset values regardless of position. There is no partial-line or partial-frame completion.
- Counter compare width: all compares are done at CNT_W bits, unsigned. There is no overflow path, because counts never exceed TOTAL-1.
- Active video is !hblnk && !vblnk; it is not an output.

Test Plan:
- Hold rst 3 cycles, then release -> all outputs 0 during reset; first post-reset sample is hcount=1, vcount=0, flags 0, frame_start 0.
- Run one line -> hblnk rises at hcount=1024 and stays high through 1343. hsync is high exactly for hcount 1048..1183 (136 cycles). At 1343->0, vcount goes 0->1.
- Run to vertical blank -> vblnk rises with vcount=768 at hcount=0. vsync is high for vcount 771..776 (6 lines = 8064 cycles).
- Frame wrap: at (1343,805) the next sample is (0,0) with frame_start=1 for one cycle. Frame period is exactly 1344*806 = 1083264 cycles between strobes.
- Reset mid-frame at (500,400) -> next sample is all-zero outputs. The release sequence then restarts as in the first scenario, and no frame_start appears until a full frame elapses.
- Self-checking scoreboard over 2 full frames: every sample's flags match the range equations for its own hcount/vcount, and hcount/vcount never exceed 1343/805.
